// File: rtl/demux_fifo_2lane_pkg.sv
// Shared constants for the two-lane demultiplexing FIFO: default widths/depth
// and the selector values that pick each lane.
package demux_fifo_2lane_pkg;

  localparam int DEF_DATA_W = 2;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_PTR_W  = 2;
  localparam int DEF_CNT_W  = 5;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/demux_fifo_2lane_fifo_lane.sv
// Show-ahead FIFO for one lane; accept reports whether this cycle's push
// was taken, so the top can detect refused writes.
module fifo_lane #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              accept
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              pop_eff;

  assign valid   = (cnt_q != '0);
  assign full    = (cnt_q == DEPTH_C);
  assign pop_eff = pop & valid;
  // A pop on a full lane frees the slot the same-cycle push needs.
  assign accept  = push & (~full | pop_eff);
  assign dout    = valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (accept)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_eff) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({accept, pop_eff})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/demux_fifo_2lane.sv
// Steers one shared write stream into two independent show-ahead lane FIFOs
// and counts (saturating) writes refused because the target lane was full.
module demux_fifo_2lane
  import demux_fifo_2lane_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = DEF_PTR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              selector,
  input  logic              pop0,
  input  logic              pop1,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              full0,
  output logic              full1,
  output logic [CNT_W-1:0]  drop_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic push0, push1;
  logic accept0, accept1;
  logic drop;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  assign push0 = valid_in & (selector == LANE0);
  assign push1 = valid_in & (selector == LANE1);

  fifo_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_lane0 (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (push0),
    .pop     (pop0),
    .din     (data_in),
    .dout    (data_out0),
    .valid   (valid_out0),
    .full    (full0),
    .accept  (accept0)
  );

  fifo_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_lane1 (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (push1),
    .pop     (pop1),
    .din     (data_in),
    .dout    (data_out1),
    .valid   (valid_out1),
    .full    (full1),
    .accept  (accept1)
  );

  // Only one lane is targeted per cycle, so a refusal is a push its lane did not accept.
  assign drop = (push0 & ~accept0) | (push1 & ~accept1);

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop) drop_count_d = sat_inc(drop_count_q);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) drop_count_q <= '0;
    else          drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux_fifo_2lane.sv
// Directed plus random bench for demux_fifo_2lane with per-lane queue scoreboards.
module tb_demux_fifo_2lane;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [1:0] data_in;
  logic       valid_in;
  logic       selector;
  logic       pop0, pop1;
  logic [1:0] data_out0, data_out1;
  logic       valid_out0, valid_out1;
  logic       full0, full1;
  logic [4:0] drop_count;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] q0 [$];
  logic [1:0] q1 [$];
  int         m_drops = 0;

  always #5 clk = ~clk;

  demux_fifo_2lane dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .selector   (selector),
    .pop0       (pop0),
    .pop1       (pop1),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .full0      (full0),
    .full1      (full1),
    .drop_count (drop_count)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    cmp("valid_out0", 32'(valid_out0), 32'(q0.size() != 0));
    cmp("data_out0",  32'(data_out0),  (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
    cmp("full0",      32'(full0),      32'(q0.size() == 4));
    cmp("valid_out1", 32'(valid_out1), 32'(q1.size() != 0));
    cmp("data_out1",  32'(data_out1),  (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
    cmp("full1",      32'(full1),      32'(q1.size() == 4));
    cmp("drop_count", 32'(drop_count), 32'(m_drops));
  endtask

  // Drive one cycle's inputs, advance the scoreboard across the edge, then check.
  task automatic cycle(input logic vin, input logic sel, input logic [1:0] din,
                       input logic p0, input logic p1);
    bit pe0, pe1, tgt_pop, acc;
    int tgt_size;
    valid_in = vin; selector = sel; data_in = din; pop0 = p0; pop1 = p1;
    @(posedge clk);
    pe0 = p0 && (q0.size() != 0);
    pe1 = p1 && (q1.size() != 0);
    tgt_size = sel ? q1.size() : q0.size();
    tgt_pop  = sel ? pe1 : pe0;
    acc = vin && ((tgt_size < 4) || tgt_pop);
    if (pe0) void'(q0.pop_front());
    if (pe1) void'(q1.pop_front());
    if (acc) begin
      if (sel) q1.push_back(din);
      else     q0.push_back(din);
    end else if (vin && m_drops < 31) begin
      m_drops++;
    end
    #1;
    check_all();
  endtask

  initial begin
    reset_L = 1'b0; valid_in = 1'b0; selector = 1'b0; data_in = 2'b00;
    pop0 = 1'b0; pop1 = 1'b0;
    #2;
    check_all();
    @(negedge clk);
    reset_L = 1'b1;

    // single write to lane 0
    cycle(1, 0, 2'b11, 0, 0);
    cycle(0, 0, 2'b00, 1, 0);

    // alternating lanes, then drain lane 0 and lane 1
    cycle(1, 0, 2'b01, 0, 0);
    cycle(1, 1, 2'b10, 0, 0);
    cycle(1, 0, 2'b11, 0, 0);
    cycle(1, 1, 2'b00, 0, 0);
    cycle(0, 0, 2'b00, 1, 0);
    cycle(0, 0, 2'b00, 1, 0);
    cycle(0, 1, 2'b00, 0, 1);
    cycle(0, 1, 2'b00, 0, 1);

    // fill lane 1, one drop, then push+pop on the full lane
    for (int i = 0; i < 5; i++) cycle(1, 1, 2'b10, 0, 0);
    cycle(1, 1, 2'b01, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 2'b00, 0, 1);

    // saturate drop_count on a full lane 0, drain, pop while empty
    for (int i = 0; i < 4; i++) cycle(1, 0, 2'(i), 0, 0);
    for (int i = 0; i < 40; i++) cycle(1, 0, 2'b11, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 2'b00, 1, 0);
    cycle(0, 0, 2'b00, 1, 0);
    cycle(1, 0, 2'b10, 1, 0);
    cycle(0, 0, 2'b00, 1, 0);

    // asynchronous reset between edges with lane 0 partially filled
    cycle(1, 0, 2'b01, 0, 0);
    cycle(1, 0, 2'b10, 0, 0);
    cycle(1, 0, 2'b11, 0, 0);
    #2;
    reset_L = 1'b0;
    #1;
    q0.delete(); q1.delete(); m_drops = 0;
    check_all();
    #2;
    reset_L = 1'b1;
    cycle(1, 0, 2'b10, 0, 0);
    cycle(0, 0, 2'b00, 1, 0);

    // concurrent pops on both lanes plus a write to lane 0
    cycle(1, 0, 2'b01, 0, 0);
    cycle(1, 0, 2'b10, 0, 0);
    cycle(1, 1, 2'b11, 0, 0);
    cycle(1, 1, 2'b00, 0, 0);
    cycle(1, 0, 2'b11, 1, 1);
    cmp("occ0", 32'(q0.size()), 32'd2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 2'b00, 1, 1);

    // random traffic
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
